bubble_sort_ctrl: RTL and testbench

- Sequential bubble-sort scheduler. Time-shares a single internal compare-exchange unit across a register bank of DEPTH elements.
- Loads elements serially over a valid/ready handshake, then runs passes of one compare-exchange per cycle. Streams the sorted result out over a second valid/ready handshake.
- Area-lean alternative to the fully unrolled swapper-stage sorting network; same element width and enable semantics.

---
 rtl/bubble_sort_ctrl.sv | 147 ++++++++++++++
 tb/tb_bubble_sort_ctrl.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/bubble_sort_ctrl.sv
// Sequential bubble sort: serial load, one compare-exchange per cycle, serial unload.
// Optional macro BUBBLE_EARLY_EXIT_EN ends SORT after the first pass with no swaps.
module bubble_sort_ctrl #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int IW  = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int SCW = $clog2(DEPTH * (DEPTH - 1) / 2 + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_data_o,
  output logic             out_last_o,
  output logic             busy_o,
  output logic [SCW-1:0]   swap_count_o
);

  typedef enum logic [1:0] {LOAD = 2'd0, SORT = 2'd1, UNLOAD = 2'd2} state_t;

  state_t           state_q, state_d;
  logic [IW-1:0]    wr_q, wr_d, rd_q, rd_d, p_q, p_d, i_q, i_d;
  logic [SCW-1:0]   sc_q, sc_d;
  logic [WIDTH-1:0] bank_q [DEPTH];
  logic [WIDTH-1:0] bank_d [DEPTH];

  logic [IW-1:0]    i_nxt;
  logic             load_last, do_swap, pass_end, last_pass, rd_last, sort_done;

  assign i_nxt     = i_q + IW'(1);
  assign load_last = (int'(wr_q) == DEPTH - 1);
  assign do_swap   = (bank_q[i_q] > bank_q[i_nxt]);
  assign pass_end  = (int'(i_q) == DEPTH - 2 - int'(p_q));
  assign last_pass = (int'(p_q) == DEPTH - 2);
  assign rd_last   = (int'(rd_q) == DEPTH - 1);

`ifdef BUBBLE_EARLY_EXIT_EN
  logic swapped_q, swapped_d;
  // A pass that finishes without any exchange proves the bank is ordered.
  assign sort_done = pass_end && (last_pass || !(swapped_q || do_swap));
`else
  assign sort_done = pass_end && last_pass;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= LOAD;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (en_i) begin
      case (state_q)
        LOAD:    if (in_valid_i && load_last) state_d = SORT;
        SORT:    if (sort_done) state_d = UNLOAD;
        UNLOAD:  if (out_ready_i && rd_last) state_d = LOAD;
        default: state_d = LOAD;
      endcase
    end
  end

  always_comb begin
    in_ready_o   = en_i && (state_q == LOAD);
    out_valid_o  = en_i && (state_q == UNLOAD);
    out_last_o   = (state_q == UNLOAD) && rd_last;
    busy_o       = (state_q == SORT);
    out_data_o   = bank_q[rd_q];
    swap_count_o = sc_q;
  end

  always_comb begin
    bank_d = bank_q;
    wr_d   = wr_q;
    rd_d   = rd_q;
    p_d    = p_q;
    i_d    = i_q;
    sc_d   = sc_q;
`ifdef BUBBLE_EARLY_EXIT_EN
    swapped_d = swapped_q;
`endif
    if (en_i) begin
      case (state_q)
        LOAD: if (in_valid_i) begin
          bank_d[wr_q] = in_data_i;
          if (load_last) begin
            wr_d = '0;
            p_d  = '0;
            i_d  = '0;
            sc_d = '0;
`ifdef BUBBLE_EARLY_EXIT_EN
            swapped_d = 1'b0;
`endif
          end else begin
            wr_d = wr_q + IW'(1);
          end
        end
        SORT: begin
          if (do_swap) begin
            bank_d[i_q]   = bank_q[i_nxt];
            bank_d[i_nxt] = bank_q[i_q];
            sc_d          = sc_q + SCW'(1);
          end
          if (pass_end) begin
            i_d = '0;
            p_d = p_q + IW'(1);
          end else begin
            i_d = i_nxt;
          end
`ifdef BUBBLE_EARLY_EXIT_EN
          swapped_d = pass_end ? 1'b0 : (swapped_q || do_swap);
`endif
        end
        UNLOAD: if (out_ready_i) rd_d = rd_last ? '0 : rd_q + IW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k < DEPTH; k++) bank_q[k] <= '0;
      wr_q <= '0;
      rd_q <= '0;
      p_q  <= '0;
      i_q  <= '0;
      sc_q <= '0;
`ifdef BUBBLE_EARLY_EXIT_EN
      swapped_q <= 1'b0;
`endif
    end else begin
      bank_q <= bank_d;
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      p_q    <= p_d;
      i_q    <= i_d;
      sc_q   <= sc_d;
`ifdef BUBBLE_EARLY_EXIT_EN
      swapped_q <= swapped_d;
`endif
    end
  end

endmodule

// File: tb/tb_bubble_sort_ctrl.sv
// Directed bench for bubble_sort_ctrl (WIDTH=8, DEPTH=4); honours BUBBLE_EARLY_EXIT_EN.
module tb_bubble_sort_ctrl;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic       en_i;
  logic       in_valid_i;
  logic       in_ready_o;
  logic [7:0] in_data_i;
  logic       out_valid_o;
  logic       out_ready_i;
  logic [7:0] out_data_o;
  logic       out_last_o;
  logic       busy_o;
  logic [2:0] swap_count_o;

  int n_vec  = 0;
  int n_miss = 0;
  int busy_cnt;

`ifdef BUBBLE_EARLY_EXIT_EN
  localparam int SORTED_BUSY = 3;
`else
  localparam int SORTED_BUSY = 6;
`endif

  bubble_sort_ctrl #(.WIDTH(8), .DEPTH(4)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .en_i(en_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_data_i(in_data_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_data_o(out_data_o),
    .out_last_o(out_last_o), .busy_o(busy_o), .swap_count_o(swap_count_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // All tasks start and end at a falling edge.
  task automatic load_job(input logic [7:0] a, b, c, d);
    logic [7:0] v [4];
    v = '{a, b, c, d};
    for (int k = 0; k < 4; k++) begin
      in_valid_i = 1'b1;
      in_data_i  = v[k];
      #1;
      chk("in_ready", in_ready_o, 1);
      @(negedge clk_i);
    end
    in_valid_i = 1'b0;
  endtask

  task automatic measure_busy(input int drop_at, input int drop_len, output int cnt);
    bit done = 0;
    cnt = 0;
    out_ready_i = 1'b0;
    for (int c = 0; c < 64 && !done; c++) begin
      en_i = !(c >= drop_at && c < drop_at + drop_len);
      in_valid_i = !en_i;
      #1;
      if (!en_i) begin
        chk("frz_in_ready", in_ready_o, 0);
        chk("frz_out_valid", out_valid_o, 0);
      end
      if (out_valid_o) done = 1;
      else begin
        if (busy_o) cnt++;
        @(negedge clk_i);
      end
    end
    en_i = 1'b1;
    in_valid_i = 1'b0;
    if (!done) chk("sort_timeout", 0, 1);
  endtask

  task automatic unload_job(input logic [7:0] a, b, c, d, input logic [15:0] pat);
    logic [7:0] e [4];
    int k = 0;
    e = '{a, b, c, d};
    for (int c = 0; c < 32 && k < 4; c++) begin
      out_ready_i = (c < 16) ? pat[c] : 1'b1;
      #1;
      chk("out_valid", out_valid_o, 1);
      chk("out_data", out_data_o, e[k]);
      chk("out_last", out_last_o, (k == 3) ? 1 : 0);
      if (out_valid_o && out_ready_i) k++;
      @(negedge clk_i);
    end
    out_ready_i = 1'b0;
    chk("unload_count", k, 4);
    #1;
    chk("post_in_ready", in_ready_o, 1);
    chk("post_out_valid", out_valid_o, 0);
    @(negedge clk_i);
  endtask

  initial begin
    rst_ni = 1'b0; en_i = 1'b1; in_valid_i = 1'b0; in_data_i = '0; out_ready_i = 1'b0;
    @(negedge clk_i); #1;
    chk("rst_in_ready", in_ready_o, 1);
    chk("rst_out_valid", out_valid_o, 0);
    chk("rst_out_last", out_last_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_out_data", out_data_o, 0);
    chk("rst_swaps", swap_count_o, 0);
    rst_ni = 1'b1;
    @(negedge clk_i);

    load_job(4, 3, 2, 1);
    measure_busy(99, 0, busy_cnt);
    chk("busy_4321", busy_cnt, 6);
    unload_job(1, 2, 3, 4, 16'hFFFF);
    chk("swaps_4321", swap_count_o, 6);

    load_job(5, 5, 0, 255);
    measure_busy(99, 0, busy_cnt);
    chk("busy_5502", busy_cnt, 6);
    unload_job(0, 5, 5, 255, 16'hFFFF);
    chk("swaps_5502", swap_count_o, 2);

    load_job(1, 2, 3, 4);
    measure_busy(99, 0, busy_cnt);
    chk("busy_sorted", busy_cnt, SORTED_BUSY);
    unload_job(1, 2, 3, 4, 16'hFFFF);
    chk("swaps_sorted", swap_count_o, 0);

    // out_ready pattern 0,1,0,0,1,0,1,1...
    load_job(4, 3, 2, 1);
    measure_busy(99, 0, busy_cnt);
    unload_job(1, 2, 3, 4, 16'hFFD2);
    chk("swaps_stall", swap_count_o, 6);

    load_job(7, 1, 9, 3);
    measure_busy(2, 5, busy_cnt);
    chk("busy_en_drop", busy_cnt, 11);
    unload_job(1, 3, 7, 9, 16'hFFFF);
    chk("swaps_en_drop", swap_count_o, 3);

    load_job(9, 8, 7, 6);
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("pre_rst_busy", busy_o, 1);
      @(negedge clk_i);
    end
    rst_ni = 1'b0;
    #1;
    chk("mid_rst_busy", busy_o, 0);
    chk("mid_rst_out_valid", out_valid_o, 0);
    chk("mid_rst_in_ready", in_ready_o, 1);
    chk("mid_rst_swaps", swap_count_o, 0);
    rst_ni = 1'b1;
    @(negedge clk_i);
    load_job(9, 8, 7, 6);
    measure_busy(99, 0, busy_cnt);
    chk("busy_9876", busy_cnt, 6);
    unload_job(6, 7, 8, 9, 16'hFFFF);
    chk("swaps_9876", swap_count_o, 6);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
